// File: rtl/arith_ctrl.sv
// arith_ctrl: byte-serial 32-bit add/sub/compare/pass-b unit.
// One 8-bit slice per cycle, LSB first, four RUN cycles per operation.
// Result flags and f update only when the last slice completes.
module arith_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] f,
    output logic        C,
    output logic        V,
    output logic        Z,
    output logic        eq,
    output logic        gr,
    output logic        ls,
    output logic        busy,
    output logic        done
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    typedef enum logic [1:0] {
        OP_ADD  = 2'b00,
        OP_SUB  = 2'b01,
        OP_CMP  = 2'b10,
        OP_PASS = 2'b11
    } op_t;

    state_t      state, state_nxt;
    op_t         rop;
    logic [31:0] ra, rb, acc;
    logic [1:0]  idx;
    logic        cy;

    logic        accept;
    logic        is_sub;
    logic [7:0]  ab, bb;
    logic [8:0]  s;
    logic        c7;
    logic [31:0] res;
    logic        res_z;

    // New operation accepted whenever the unit is not busy
    always_comb begin
        accept = start && (state != RUN);
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = RUN;
            RUN:     if (idx == 2'd3) state_nxt = DONE;
            DONE:    state_nxt = start ? RUN : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Status outputs decoded from state
    always_comb begin
        busy = (state == RUN);
        done = (state == DONE);
    end

    // Current slice adder; pass-b routes the b slice through a zero a slice
    always_comb begin
        is_sub = (rop == OP_SUB) || (rop == OP_CMP);
        ab     = ra[{idx, 3'b000} +: 8];
        bb     = rb[{idx, 3'b000} +: 8];
        if (rop == OP_PASS) ab = '0;
        if (is_sub)         bb = ~bb;
        s      = {1'b0, ab} + {1'b0, bb} + {8'b0, cy};
        // carry into bit 7 of the slice; on the last slice this is carry into bit 31
        c7     = s[7] ^ ab[7] ^ bb[7];
        res    = {s[7:0], acc[23:0]};
        res_z  = (res == '0);
    end

    // Operand latch, slice accumulation and final output update
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ra  <= '0;
            rb  <= '0;
            rop <= OP_ADD;
            acc <= '0;
            idx <= '0;
            cy  <= 1'b0;
            f   <= '0;
            C   <= 1'b0;
            V   <= 1'b0;
            Z   <= 1'b0;
            eq  <= 1'b0;
            gr  <= 1'b0;
            ls  <= 1'b0;
        end else if (accept) begin
            ra  <= a;
            rb  <= b;
            rop <= op_t'(op);
            idx <= '0;
            cy  <= (op_t'(op) == OP_SUB) || (op_t'(op) == OP_CMP);
        end else if (state == RUN) begin
            acc[{idx, 3'b000} +: 8] <= s[7:0];
            cy  <= s[8];
            idx <= idx + 2'd1;
            if (idx == 2'd3) begin
                case (rop)
                    OP_ADD, OP_SUB: begin
                        f <= res;
                        C <= s[8];
                        V <= c7 ^ s[8];
                        Z <= res_z;
                    end
                    OP_CMP: begin
                        C <= s[8];
                        V <= c7 ^ s[8];
                        Z <= res_z;
                    end
                    default: begin
                        f <= res;
                        C <= 1'b0;
                        V <= 1'b0;
                        Z <= res_z;
                    end
                endcase
                eq <= is_sub & res_z;
                gr <= is_sub & s[8] & ~res_z;
                ls <= is_sub & ~s[8];
            end
        end
    end

endmodule

// File: tb/tb_arith_ctrl.sv
// Scoreboard bench for arith_ctrl: driver pushes expected results from a
// plain-arithmetic model, monitor pops and compares on every done pulse.
module tb_arith_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [1:0]  op;
    logic [31:0] a, b;
    logic [31:0] f;
    logic        C, V, Z, eq, gr, ls, busy, done;

    arith_ctrl dut (
        .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
        .f(f), .C(C), .V(V), .Z(Z), .eq(eq), .gr(gr), .ls(ls),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] f;
        logic        c, v, z, eq, gr, ls;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] model_f = '0;
    logic [31:0] last_f  = '0;
    int          tests   = 0;
    int          fails   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: whole-word arithmetic
    function automatic exp_t model(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
        exp_t        e;
        logic [32:0] s;
        logic [31:0] d;
        e = '{f: model_f, c: 1'b0, v: 1'b0, z: 1'b0, eq: 1'b0, gr: 1'b0, ls: 1'b0};
        case (o)
            2'd0: begin
                s   = {1'b0, x} + {1'b0, y};
                e.f = s[31:0];
                e.c = s[32];
                e.v = (x[31] == y[31]) && (s[31] != x[31]);
                e.z = (s[31:0] == 0);
            end
            2'd1, 2'd2: begin
                d    = x - y;
                e.c  = (x >= y);
                e.v  = (x[31] != y[31]) && (d[31] != x[31]);
                e.z  = (x == y);
                e.eq = (x == y);
                e.gr = (x > y);
                e.ls = (x < y);
                if (o == 2'd1) e.f = d;
            end
            default: begin
                e.f = y;
                e.z = (y == 0);
            end
        endcase
        return e;
    endfunction

    // Entered at a negedge with busy==0; returns at the negedge of the done cycle
    task automatic run_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                          input bit hold, input bit midpulse);
        exp_t e;
        start = 1'b1; op = o; a = x; b = y;
        e = model(o, x, y);
        model_f = e.f;
        sb.push_back(e);
        @(posedge clk); #1;
        if (!hold) begin
            start = 1'b0;
            op = 2'($urandom); a = $urandom; b = $urandom;
        end
        for (int i = 1; i <= 4; i++) begin
            @(negedge clk);
            chk($sformatf("busy_c%0d", i), 64'(busy), 64'd1);
            chk($sformatf("done_low_c%0d", i), 64'(done), 64'd0);
            if (midpulse && i == 2) start = 1'b1;
            if (midpulse && i == 3) start = 1'b0;
        end
        @(negedge clk);
        chk("done_pulse", 64'(done), 64'd1);
        chk("busy_in_done", 64'(busy), 64'd0);
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 4))
            0:       return 32'h0;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            default: return $urandom;
        endcase
    endfunction

    // Monitor: compare on done, check f holds during RUN
    always @(negedge clk) begin
        if (!rst) begin
            if (done) begin
                if (sb.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_done: got done=1 expected no pending op at %0t", $time);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("result{f,C,V,Z,eq,gr,ls}", 64'({f, C, V, Z, eq, gr, ls}),
                        64'({e.f, e.c, e.v, e.z, e.eq, e.gr, e.ls}));
                    last_f = e.f;
                end
            end else if (busy) begin
                chk("f_hold_run", 64'(f), 64'(last_f));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1; start = 1'b0; op = '0; a = '0; b = '0;
        @(negedge clk);
        chk("reset_outputs", 64'({f, C, V, Z, eq, gr, ls, busy, done}), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        run_op(2'd0, 32'h0000_00FF, 32'h0000_0001, 1'b0, 1'b0);
        run_op(2'd1, 32'h8000_0000, 32'h0000_0001, 1'b0, 1'b0);
        run_op(2'd3, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b0, 1'b0);
        run_op(2'd2, 32'h1234_5678, 32'h1234_5678, 1'b0, 1'b0);
        chk("cmp_keeps_f", 64'(f), 64'h0000_0000_DEAD_BEEF);
        run_op(2'd2, 32'h0000_0001, 32'h0000_0002, 1'b0, 1'b0);
        run_op(2'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b1);

        for (int n = 0; n < 40; n++)
            run_op(2'($urandom_range(0, 3)), pick(), pick(), 1'b0, bit'($urandom_range(0, 1)));

        // Reset during the second RUN cycle
        start = 1'b1; op = 2'd0; a = 32'h0000_1000; b = 32'h0000_0234;
        sb.push_back(model(2'd0, a, b));
        @(posedge clk); #1;
        start = 1'b0;
        @(negedge clk);
        @(posedge clk); #2;
        rst = 1'b1;
        #1;
        chk("async_reset_outputs", 64'({f, C, V, Z, eq, gr, ls, busy, done}), 64'd0);
        sb.delete();
        model_f = '0;
        last_f  = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("no_done_after_abort", 64'({busy, done}), 64'd0);
        end
        run_op(2'd0, 32'd2, 32'd3, 1'b0, 1'b0);
        chk("add_after_reset", 64'(f), 64'd5);

        // Start held high: back-to-back pass-b of zero
        for (int n = 0; n < 3; n++) begin
            run_op(2'd3, 32'h0, 32'h0, 1'b1, 1'b0);
            chk("held_pass_f", 64'(f), 64'd0);
            chk("held_pass_z", 64'(Z), 64'd1);
        end
        start = 1'b0;
        repeat (3) @(negedge clk);
        chk("idle_after_held", 64'({busy, done}), 64'd0);
        chk("scoreboard_empty", 64'(sb.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
